// File: rtl/song_sequencer_if.sv
// Sequencer-side bundle: play/song/beat controls, song ROM port and note-player outputs.
// No backpressure; the ROM answers one cycle after rom_addr and the note player always accepts.
interface song_sequencer_if #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
);
  logic                          play;
  logic [SONG_BITS-1:0]          song;
  logic                          beat;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic [NOTE_W+DUR_W-1:0]       rom_dout;
  logic [NOTE_W-1:0]             note;
  logic [DUR_W-1:0]              duration;
  logic                          new_note;
  logic                          note_valid;
  logic                          song_done;

  modport master (
    output play, song, beat, rom_dout,
    input  rom_addr, note, duration, new_note, note_valid, song_done
  );

  modport slave (
    input  play, song, beat, rom_dout,
    output rom_addr, note, duration, new_note, note_valid, song_done
  );
endinterface

// File: rtl/song_sequencer.sv
// Song ROM playback controller; new_note 3 cycles after play rises, 2 dead cycles between entries.
// No backpressure: beats are counted only while play=1, song changes restart the fetch immediately.
module song_sequencer #(
  parameter int SONG_BITS = 2,
  parameter int IDX_BITS  = 5,
  parameter int NOTE_W    = 6,
  parameter int DUR_W     = 6
) (
  input logic              clk,
  input logic              rst_n,
  song_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_t;

  state_t               state;
  logic [SONG_BITS-1:0] song_q;
  logic [IDX_BITS-1:0]  idx;
  logic [DUR_W-1:0]     beat_cnt;
  logic                 play_q;
  logic [NOTE_W-1:0]    note_q;
  logic [DUR_W-1:0]     dur_q;
  logic                 new_note_q;
  logic                 song_done_q;

  logic                 play_rise;
  logic                 song_chg;
  logic [DUR_W:0]       cnt_inc;
  logic                 end_of_note;
  logic                 last_idx;
  logic [NOTE_W-1:0]    rom_note;
  logic [DUR_W-1:0]     rom_dur;

  assign play_rise   = bus.play & ~play_q;
  assign song_chg    = (bus.song != song_q);
  assign cnt_inc     = {1'b0, beat_cnt} + (DUR_W+1)'(1);
  assign end_of_note = (cnt_inc == {1'b0, dur_q});
  assign last_idx    = &idx;
  assign rom_note    = bus.rom_dout[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur     = bus.rom_dout[DUR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      song_q      <= '0;
      idx         <= '0;
      beat_cnt    <= '0;
      play_q      <= 1'b0;
      note_q      <= '0;
      dur_q       <= '0;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      play_q      <= bus.play;
      new_note_q  <= 1'b0;
      song_done_q <= 1'b0;
      // A song change outranks beats and end-of-note in every active state.
      if ((state == FETCH || state == WAIT || state == PLAY) && song_chg) begin
        song_q   <= bus.song;
        idx      <= '0;
        beat_cnt <= '0;
        state    <= FETCH;
      end else begin
        case (state)
          IDLE: begin
            song_q <= bus.song;
            idx    <= '0;
            if (play_rise) state <= FETCH;
          end
          FETCH: state <= WAIT;
          WAIT: begin
            if (rom_dur == '0) begin
              note_q      <= '0;
              dur_q       <= '0;
              song_done_q <= 1'b1;
              state       <= DONE;
            end else begin
              note_q     <= rom_note;
              dur_q      <= rom_dur;
              beat_cnt   <= '0;
              new_note_q <= 1'b1;
              state      <= PLAY;
            end
          end
          PLAY: begin
            if (bus.beat && bus.play) begin
              if (end_of_note) begin
                beat_cnt <= '0;
                if (last_idx) begin
                  note_q      <= '0;
                  dur_q       <= '0;
                  song_done_q <= 1'b1;
                  state       <= DONE;
                end else begin
                  idx   <= idx + IDX_BITS'(1);
                  state <= FETCH;
                end
              end else begin
                beat_cnt <= cnt_inc[DUR_W-1:0];
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rom_addr   = {song_q, idx};
  assign bus.note       = note_q;
  assign bus.duration   = dur_q;
  assign bus.new_note   = new_note_q;
  assign bus.song_done  = song_done_q;
  // Pause is visible the same cycle play drops.
  assign bus.note_valid = (state == PLAY) & bus.play;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a registered song ROM model and hand-computed expectations.
module tb_song_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   nn_cnt = 0;
  int   done_cnt = 0;
  int   last_note = 0;
  int   last_dur = 0;
  bit   rest_seen = 0;
  bit   addr_watch = 0;
  bit   addr_bad = 0;
  bit   ok;
  int   bsince;

  song_sequencer_if #(.SONG_BITS(2), .IDX_BITS(5), .NOTE_W(6), .DUR_W(6)) bus ();

  song_sequencer #(.SONG_BITS(2), .IDX_BITS(5), .NOTE_W(6), .DUR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // song0: {49,12},{1,8}, rest at 5, end marker at 28; song1: {35,36},{20,4}; song2: {i+8,3}; song3: rest at 0, {63,12} at 31
  function automatic logic [11:0] rom_fn(input logic [6:0] a);
    logic [4:0] i;
    logic [5:0] n;
    logic [5:0] d;
    i = a[4:0];
    n = {1'b0, i};
    d = 6'd1;
    case (a[6:5])
      2'd0: begin
        if (i == 5'd0)       begin n = 6'd49; d = 6'd12; end
        else if (i == 5'd1)  begin n = 6'd1;  d = 6'd8;  end
        else if (i == 5'd5)  begin n = 6'd0;  d = 6'd2;  end
        else if (i == 5'd28) begin n = 6'd37; d = 6'd0;  end
      end
      2'd1: begin
        if (i == 5'd0)      begin n = 6'd35; d = 6'd36; end
        else if (i == 5'd1) begin n = 6'd20; d = 6'd4;  end
        else d = 6'd2;
      end
      2'd2: begin n = {1'b0, i} + 6'd8; d = 6'd3; end
      default: begin
        if (i == 5'd31) begin n = 6'd63; d = 6'd12; end
        else d = 6'd2;
      end
    endcase
    return {n, d};
  endfunction

  always @(posedge clk) bus.rom_dout <= rom_fn(bus.rom_addr);

  always @(posedge clk) begin
    if (bus.new_note) begin
      nn_cnt++;
      last_note = int'(bus.note);
      last_dur  = int'(bus.duration);
      if (bus.note == 6'd0 && bus.note_valid) rest_seen = 1;
    end
    if (bus.song_done) done_cnt++;
    if (addr_watch && bus.rom_addr < 7'd96) addr_bad = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic beats(input int n);
    for (int k = 0; k < n; k++) begin
      bus.beat = 1'b1; cyc();
      bus.beat = 1'b0; cyc();
    end
  endtask

  // Alternating beats until song_done; bs counts beats issued since the last new_note.
  task automatic run_until_done(input int max, output bit got, output int bs);
    got = 0;
    bs  = 0;
    for (int k = 0; k < max; k++) begin
      bus.beat = (k % 2 == 0);
      cyc();
      if (bus.new_note) bs = 0;
      else if (bus.beat) bs++;
      if (bus.song_done) begin
        got = 1;
        break;
      end
    end
    bus.beat = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bus.play = 1'b0; bus.song = 2'd0; bus.beat = 1'b0;
    cyc(); cyc();
    chk("rst_note", bus.note, 0);
    chk("rst_duration", bus.duration, 0);
    chk("rst_new_note", bus.new_note, 0);
    chk("rst_note_valid", bus.note_valid, 0);
    chk("rst_song_done", bus.song_done, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);

    // song 0: first entries and latency
    rst_n = 1'b1; bus.play = 1'b1; nn_cnt = 0;
    cyc();
    chk("s0_fetch_addr", bus.rom_addr, 0);
    chk("s0_fetch_nv", bus.note_valid, 0);
    cyc();
    chk("s0_wait_nn", bus.new_note, 0);
    cyc();
    chk("s0_first_nn", bus.new_note, 1);
    chk("s0_first_note", bus.note, 49);
    chk("s0_first_dur", bus.duration, 12);
    chk("s0_first_nv", bus.note_valid, 1);
    beats(11);
    chk("s0_hold_note", bus.note, 49);
    beats(1);
    chk("s0_gap_addr", bus.rom_addr, 1);
    chk("s0_gap_nv", bus.note_valid, 0);
    chk("s0_gap_nn", bus.new_note, 0);
    cyc();
    chk("s0_e1_nn", bus.new_note, 1);
    chk("s0_e1_note", bus.note, 1);
    chk("s0_e1_dur", bus.duration, 8);

    done_cnt = 0;
    run_until_done(2000, ok, bsince);
    chk("s0_done_reached", ok, 1);
    chk("s0_nn_count", nn_cnt, 28);
    chk("s0_done_note", bus.note, 0);
    chk("s0_done_dur", bus.duration, 0);
    chk("s0_done_nv", bus.note_valid, 0);
    cyc();
    chk("s0_done_pulse", bus.song_done, 0);
    beats(10);
    chk("s0_no_loop_nn", nn_cnt, 28);
    chk("s0_done_once", done_cnt, 1);

    // song 3: all 32 entries, never leaves its address range
    bus.play = 1'b0; bus.song = 2'd3;
    cyc(); cyc();
    nn_cnt = 0; rest_seen = 0; addr_watch = 1; addr_bad = 0;
    bus.play = 1'b1;
    run_until_done(5000, ok, bsince);
    addr_watch = 0;
    cyc();
    chk("s3_done_reached", ok, 1);
    chk("s3_nn_count", nn_cnt, 32);
    chk("s3_addr_range", addr_bad, 0);
    chk("s3_last_note", last_note, 63);
    chk("s3_last_dur", last_dur, 12);
    chk("s3_last_beats", bsince, 12);
    chk("s3_rest_valid", rest_seen, 1);

    // song 1: pause in the middle of a 36-beat entry
    bus.play = 1'b0; bus.song = 2'd1;
    cyc(); cyc();
    nn_cnt = 0;
    bus.play = 1'b1;
    cyc();
    chk("s1_fetch_addr", bus.rom_addr, 32);
    cyc(); cyc();
    chk("s1_nn", bus.new_note, 1);
    chk("s1_note", bus.note, 35);
    chk("s1_dur", bus.duration, 36);
    beats(5);
    bus.play = 1'b0;
    cyc();
    chk("pause_nv", bus.note_valid, 0);
    beats(100);
    chk("pause_nv_held", bus.note_valid, 0);
    chk("pause_note_held", bus.note, 35);
    bus.play = 1'b1;
    cyc();
    chk("resume_nv", bus.note_valid, 1);
    beats(30);
    chk("resume_not_yet", nn_cnt, 1);
    chk("resume_note", bus.note, 35);
    beats(1);
    chk("resume_adv_addr", bus.rom_addr, 33);
    chk("resume_gap_nv", bus.note_valid, 0);
    cyc();
    chk("s1_e1_nn", bus.new_note, 1);
    chk("s1_e1_note", bus.note, 20);
    chk("s1_e1_dur", bus.duration, 4);

    // song change: to song 2, advance to entry 70, then switch on a final beat
    bus.song = 2'd2;
    cyc();
    chk("chg_s2_addr", bus.rom_addr, 64);
    cyc(); cyc();
    chk("s2_e0_note", bus.note, 8);
    chk("s2_e0_dur", bus.duration, 3);
    for (int e = 0; e < 6; e++) begin
      beats(3);
      cyc();
    end
    chk("s2_e6_addr", bus.rom_addr, 70);
    chk("s2_e6_nn", bus.new_note, 1);
    chk("s2_e6_note", bus.note, 14);
    beats(2);
    bus.song = 2'd1; bus.beat = 1'b1;
    cyc();
    bus.beat = 1'b0;
    chk("chg_s1_addr", bus.rom_addr, 32);
    chk("chg_s1_nn0", bus.new_note, 0);
    cyc();
    chk("chg_wait_nv", bus.note_valid, 0);
    cyc();
    chk("chg_nn", bus.new_note, 1);
    chk("chg_note", bus.note, 35);
    chk("chg_dur", bus.duration, 36);

    // reset in the middle of a note, then restart with a pause across FETCH/WAIT
    beats(3);
    rst_n = 1'b0; bus.play = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("mid_rst_note", bus.note, 0);
    chk("mid_rst_dur", bus.duration, 0);
    chk("mid_rst_nv", bus.note_valid, 0);
    chk("mid_rst_done", bus.song_done, 0);
    chk("mid_rst_nn", bus.new_note, 0);
    chk("mid_rst_addr", bus.rom_addr, 0);
    cyc();
    nn_cnt = 0;
    beats(5);
    chk("idle_no_nn", nn_cnt, 0);
    chk("idle_addr", bus.rom_addr, 32);
    bus.play = 1'b1;
    cyc();
    bus.play = 1'b0;
    cyc(); cyc();
    chk("restart_nn", bus.new_note, 1);
    chk("restart_note", bus.note, 35);
    chk("restart_paused_nv", bus.note_valid, 0);
    bus.play = 1'b1;
    cyc();
    chk("restart_nv", bus.note_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
